// File: rtl/bypass_ctrl_pkg.sv
// rtl/bypass_ctrl_pkg.sv - shared bypass select codes, stage metadata and match helper
package bypass_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] BYP_RF  = 2'd0;
  localparam logic [1:0] BYP_MEM = 2'd1;
  localparam logic [1:0] BYP_WB  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwen;
    logic              memread;
  } stage_meta_t;

  // x0 is hardwired zero, so it never counts as a producer
  function automatic logic writes_reg(stage_meta_t s, logic [REG_AW-1:0] r);
    return s.valid & s.regwen & (s.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/bypass_sel.sv
// rtl/bypass_sel.sv - operand bypass select for one source register
module bypass_sel
  import bypass_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  stage_meta_t       x_meta,
  input  stage_meta_t       m_meta,
  output logic [1:0]        sel
);

  // X is checked first so the youngest producer wins
  always_comb begin
    sel = BYP_RF;
    if (use_src && writes_reg(x_meta, src)) begin
      sel = BYP_MEM;
    end else if (use_src && writes_reg(m_meta, src)) begin
      sel = BYP_WB;
    end
  end

endmodule

// File: rtl/bypass_ctrl.sv
// rtl/bypass_ctrl.sv - hazard, forwarding and flush control for the 5-stage pipeline
module bypass_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_regwen,
  input  logic              d_memread,
  input  logic              x_br_taken,
  output logic [1:0]        ASelBypass,
  output logic [1:0]        BSelBypass,
  output logic              stall,
  output logic              flush,
  output logic              d_wb_fwd_rs1,
  output logic              d_wb_fwd_rs2,
  output logic [CNT_W-1:0]  stall_count
);

  import bypass_ctrl_pkg::*;

  stage_meta_t      x_q, x_d;
  stage_meta_t      m_q, m_d;
  stage_meta_t      w_q, w_d;
  logic [1:0]       asel_q, asel_d;
  logic [1:0]       bsel_q, bsel_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic       load_use;
  logic [1:0] a_sel_raw;
  logic [1:0] b_sel_raw;

  bypass_sel u_sel_a (
    .src     (d_rs1),
    .use_src (d_use_rs1),
    .x_meta  (x_q),
    .m_meta  (m_q),
    .sel     (a_sel_raw)
  );

  bypass_sel u_sel_b (
    .src     (d_rs2),
    .use_src (d_use_rs2),
    .x_meta  (x_q),
    .m_meta  (m_q),
    .sel     (b_sel_raw)
  );

  always_comb begin
    load_use = d_valid & x_q.valid & x_q.memread & (x_q.rd != '0) &
               ((d_use_rs1 & (d_rs1 == x_q.rd)) | (d_use_rs2 & (d_rs2 == x_q.rd)));
    flush    = x_br_taken;
    stall    = load_use & ~x_br_taken;

    d_wb_fwd_rs1 = d_use_rs1 & writes_reg(w_q, d_rs1);
    d_wb_fwd_rs2 = d_use_rs2 & writes_reg(w_q, d_rs2);

    w_d = m_q;
    m_d = x_q;

    x_d.valid   = d_valid & ~stall & ~flush;
    x_d.rd      = d_rd;
    x_d.regwen  = d_regwen;
    x_d.memread = d_memread;

    // a bubble entering X must never steer the execute muxes
    asel_d = x_d.valid ? a_sel_raw : BYP_RF;
    bsel_d = x_d.valid ? b_sel_raw : BYP_RF;

    stall_count_d = stall_count_q + CNT_W'(stall);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q           <= '0;
      m_q           <= '0;
      w_q           <= '0;
      asel_q        <= BYP_RF;
      bsel_q        <= BYP_RF;
      stall_count_q <= '0;
    end else begin
      x_q           <= x_d;
      m_q           <= m_d;
      w_q           <= w_d;
      asel_q        <= asel_d;
      bsel_q        <= bsel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ASelBypass  = asel_q;
  assign BSelBypass  = bsel_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_bypass_ctrl.sv
// tb/tb_bypass_ctrl.sv - directed and randomized bench for bypass_ctrl
module tb_bypass_ctrl;

  logic        clock;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_use_rs1, d_use_rs2, d_regwen, d_memread, x_br_taken;
  logic [1:0]  ASelBypass, BSelBypass;
  logic        stall, flush, d_wb_fwd_rs1, d_wb_fwd_rs2;
  logic [31:0] stall_count;

  bypass_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .d_valid      (d_valid),
    .d_rs1        (d_rs1),
    .d_rs2        (d_rs2),
    .d_use_rs1    (d_use_rs1),
    .d_use_rs2    (d_use_rs2),
    .d_rd         (d_rd),
    .d_regwen     (d_regwen),
    .d_memread    (d_memread),
    .x_br_taken   (x_br_taken),
    .ASelBypass   (ASelBypass),
    .BSelBypass   (BSelBypass),
    .stall        (stall),
    .flush        (flush),
    .d_wb_fwd_rs1 (d_wb_fwd_rs1),
    .d_wb_fwd_rs2 (d_wb_fwd_rs2),
    .stall_count  (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // issue log: entry k is the instruction that entered execute at edge k
  bit rec_v [2048];
  bit rec_w [2048];
  bit rec_m [2048];
  int rec_rd[2048];
  int cyc      = 2;
  int rst_edge = 2;
  int exp_a    = 0;
  int exp_b    = 0;
  int exp_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // instruction issued at edge k writes register r and is still remembered
  function automatic bit wr(input int k, input int r);
    if (k <= rst_edge) return 1'b0;
    return rec_v[k] && rec_w[k] && (rec_rd[k] == r) && (r != 0);
  endfunction

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit w, input bit m, input bit br);
    d_valid    = v;
    d_rs1      = 5'(rs1);
    d_use_rs1  = u1;
    d_rs2      = 5'(rs2);
    d_use_rs2  = u2;
    d_rd       = 5'(rd);
    d_regwen   = w;
    d_memread  = m;
    x_br_taken = br;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    bit lu, st, iv;
    int a, b, xr;
    @(negedge clock);
    xr = rec_rd[cyc];
    lu = d_valid && (cyc > rst_edge) && rec_v[cyc] && rec_m[cyc] && (xr != 0) &&
         ((d_use_rs1 && d_rs1 == xr) || (d_use_rs2 && d_rs2 == xr));
    st = lu && !x_br_taken;
    check_eq("stall", stall, st);
    check_eq("flush", flush, x_br_taken);
    check_eq("wb_fwd_rs1", d_wb_fwd_rs1, d_use_rs1 && wr(cyc - 2, d_rs1));
    check_eq("wb_fwd_rs2", d_wb_fwd_rs2, d_use_rs2 && wr(cyc - 2, d_rs2));
    check_eq("asel", ASelBypass, exp_a);
    check_eq("bsel", BSelBypass, exp_b);
    check_eq("stall_count", stall_count, exp_cnt);
    iv = d_valid && !st && !x_br_taken;
    a = !iv ? 0 : (d_use_rs1 && wr(cyc, d_rs1)) ? 1 : (d_use_rs1 && wr(cyc - 1, d_rs1)) ? 2 : 0;
    b = !iv ? 0 : (d_use_rs2 && wr(cyc, d_rs2)) ? 1 : (d_use_rs2 && wr(cyc - 1, d_rs2)) ? 2 : 0;
    @(posedge clock);
    #1;
    cyc++;
    rec_v[cyc]  = iv;
    rec_w[cyc]  = d_regwen;
    rec_m[cyc]  = d_memread;
    rec_rd[cyc] = d_rd;
    exp_a = a;
    exp_b = b;
    if (st) exp_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    nop();
    #2;
    check_eq("rst_asel", ASelBypass, 0);
    check_eq("rst_bsel", BSelBypass, 0);
    check_eq("rst_cnt", stall_count, 0);
    check_eq("rst_stall", stall, 0);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    cyc++;

    // ALU chain: add x5 then sub rs1=x5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); step();
    drive(1, 5, 1, 1, 1, 9, 1, 0, 0); step();
    check_eq("alu_chain_a", ASelBypass, 1);
    check_eq("alu_chain_b", BSelBypass, 0);
    nop(); step();

    // distance-2 on x6, then on x0
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); step();
    nop(); step();
    drive(1, 2, 1, 6, 1, 0, 0, 0, 0); step();
    check_eq("dist2_b", BSelBypass, 2);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step();
    nop(); step();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0); step();
    check_eq("x0_a", ASelBypass, 0);
    check_eq("x0_b", BSelBypass, 0);
    nop(); step();

    // load-use on x7
    check_eq("lu_cnt_before", stall_count, 0);
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0); step();
    drive(1, 7, 1, 0, 0, 11, 1, 0, 0);
    #1 check_eq("lu_stall", stall, 1);
    step();
    check_eq("lu_cnt_after", stall_count, 1);
    check_eq("lu_stall_released", stall, 0);
    check_eq("lu_bubble_a", ASelBypass, 0);
    step();
    check_eq("lu_a_wb", ASelBypass, 2);
    nop(); step();

    // double producer of x8
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0); step();
    drive(1, 8, 1, 0, 0, 13, 1, 0, 0); step();
    check_eq("youngest_a", ASelBypass, 1);
    nop(); step();

    // load-use coinciding with a taken branch
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0); step();
    drive(1, 9, 1, 9, 1, 12, 1, 0, 1);
    #1 check_eq("br_flush", flush, 1);
    check_eq("br_no_stall", stall, 0);
    step();
    check_eq("br_cnt_same", stall_count, 1);
    check_eq("br_bubble_a", ASelBypass, 0);
    check_eq("br_bubble_b", BSelBypass, 0);
    nop(); step();

    // async reset between edges forgets producers
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0); step();
    drive(1, 10, 1, 0, 0, 14, 1, 0, 0); step();
    check_eq("pre_rst_a", ASelBypass, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_a", ASelBypass, 0);
    check_eq("mid_rst_cnt", stall_count, 0);
    check_eq("mid_rst_stall", stall, 0);
    rst_edge = cyc;
    exp_a = 0;
    exp_b = 0;
    exp_cnt = 0;
    #1 reset = 1'b1;
    drive(1, 10, 1, 10, 1, 15, 1, 0, 0); step();
    check_eq("post_rst_a", ASelBypass, 0);
    check_eq("post_rst_b", BSelBypass, 0);

    // randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
